// File: rtl/vx_wnd_spill_unit.sv
// Register-window spill/fill engine: moves O window registers of one warp
// between the vector register file and a per-warp LIFO spill stack in memory.
module vx_wnd_spill_unit #(
  parameter int N         = 8,
  parameter int W         = 2,
  parameter int O         = 20,
  parameter int MAX_DEPTH = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] SPILL_BASE = 32'h0000_F000
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [W-1:0]      req_warp_id,
  input  logic [N-W-1:0]    req_base,
  output logic              rf_rd_en,
  output logic [N-1:0]      rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [N-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              done_valid,
  output logic [W-1:0]      done_warp_id,
  output logic              done_err,
  output logic              busy
);

  localparam int LW = N - W;
  localparam int IW = (O > 1) ? $clog2(O) : 1;
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int NW = 2 ** W;

  typedef enum logic [2:0] {
    IDLE,
    SP_RD,
    SP_WR,
    FL_REQ,
    FL_WAIT,
    DONE
  } state_t;

  state_t            r_state;
  logic [W-1:0]      r_warp;
  logic [LW-1:0]     r_base;
  logic              r_fill;
  logic              r_err;
  logic [IW-1:0]     r_idx;
  logic              r_first;
  logic [DATA_W-1:0] r_hold;
  logic [DW-1:0]     r_depth [NW];

  logic [DW-1:0]     w_cur_depth;
  logic [DW-1:0]     w_slot;
  logic [LW-1:0]     w_loc;
  logic [N-1:0]      w_reg;
  logic [ADDR_W-1:0] w_word;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last;
  logic              w_req_depth_empty;
  logic              w_req_depth_full;
  logic              w_sp_wr;
  logic              w_fl_req;
  logic              w_fl_wait;
  logic              w_done;

  assign w_cur_depth = r_depth[r_warp];
  assign w_slot = r_fill ? (w_cur_depth - DW'(1)) : w_cur_depth;
  // Local index wraps inside the window field; the warp bits never change.
  assign w_loc  = r_base + LW'(r_idx);
  assign w_reg  = {r_warp, w_loc};
  assign w_word = (ADDR_W'(r_warp) * ADDR_W'(MAX_DEPTH) + ADDR_W'(w_slot))
                  * ADDR_W'(O) + ADDR_W'(r_idx);
  assign w_addr = SPILL_BASE + (w_word << 2);
  assign w_last = (r_idx == IW'(O - 1));

  assign w_req_depth_empty = (r_depth[req_warp_id] == '0);
  assign w_req_depth_full  = (r_depth[req_warp_id] == DW'(MAX_DEPTH));

  assign w_sp_wr   = (r_state == SP_WR);
  assign w_fl_req  = (r_state == FL_REQ);
  assign w_fl_wait = (r_state == FL_WAIT);
  assign w_done    = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_warp  <= '0;
      r_base  <= '0;
      r_fill  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_first <= 1'b0;
      r_hold  <= '0;
      for (int k = 0; k < NW; k++) r_depth[k] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_warp <= req_warp_id;
            r_base <= req_base;
            r_fill <= req_fill;
            r_idx  <= '0;
            if (req_fill ? w_req_depth_empty : w_req_depth_full) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= req_fill ? FL_REQ : SP_RD;
            end
          end
        end
        SP_RD: begin
          r_first <= 1'b1;
          r_state <= SP_WR;
        end
        SP_WR: begin
          r_first <= 1'b0;
          if (r_first) r_hold <= rf_rd_data;
          if (mem_req_ready) begin
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= SP_RD;
            end
          end
        end
        FL_REQ: begin
          if (mem_req_ready) r_state <= FL_WAIT;
        end
        FL_WAIT: begin
          if (mem_rsp_valid) begin
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= FL_REQ;
            end
          end
        end
        DONE: begin
          if (!r_err) begin
            if (r_fill) r_depth[r_warp] <= w_cur_depth - DW'(1);
            else        r_depth[r_warp] <= w_cur_depth + DW'(1);
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);

  assign rf_rd_en   = (r_state == SP_RD);
  assign rf_rd_addr = rf_rd_en ? w_reg : '0;

  assign mem_req_valid = w_sp_wr | w_fl_req;
  assign mem_req_rw    = w_sp_wr;
  assign mem_req_addr  = mem_req_valid ? w_addr : '0;
  // Read data lands on the first write cycle; later stall cycles replay the hold copy.
  assign mem_req_data  = w_sp_wr ? (r_first ? rf_rd_data : r_hold) : '0;

  assign rf_wr_en   = w_fl_wait & mem_rsp_valid;
  assign rf_wr_addr = rf_wr_en ? w_reg : '0;
  assign rf_wr_data = rf_wr_en ? mem_rsp_data : '0;

  assign done_valid   = w_done;
  assign done_warp_id = w_done ? r_warp : '0;
  assign done_err     = w_done & r_err;

endmodule

// File: tb/tb_vx_wnd_spill_unit.sv
// Directed scoreboard bench for the window spill/fill engine:
// register file and memory models, expected traffic queued per request.
module tb_vx_wnd_spill_unit;

  localparam logic [31:0] SB = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic        req_fill;
  logic [1:0]  req_warp_id;
  logic [5:0]  req_base;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        done_valid;
  logic [1:0]  done_warp_id;
  logic        done_err;
  logic        busy;

  vx_wnd_spill_unit dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_fill(req_fill),
    .req_warp_id(req_warp_id), .req_base(req_base),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .done_valid(done_valid),
    .done_warp_id(done_warp_id), .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
  } mreq_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wreq_t;

  mreq_t       exp_mem [$];
  wreq_t       exp_wr  [$];
  logic [7:0]  exp_rd  [$];
  logic [2:0]  exp_done[$];
  logic [31:0] spilled [4][4][20];

  int n_cmp = 0;
  int n_mis = 0;
  int n_wr_hs = 0;
  int n_stall = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register file model: synchronous read, initialised once during reset.
  logic [31:0] rf [256];
  logic        rf_init_done = 1'b0;
  always @(posedge clk) begin
    if (nRST === 1'b0 && !rf_init_done) begin
      for (int k = 0; k < 256; k++)
        rf[k] <= 32'h5A00_0000 ^ (32'(k) * 32'h0001_9E37);
      rf_init_done <= 1'b1;
    end else begin
      if (rf_rd_en === 1'b1) rf_rd_data <= rf[rf_rd_addr];
      if (rf_wr_en === 1'b1) rf[rf_wr_addr] <= rf_wr_data;
    end
  end

  // Memory model: writes stored, reads answered one cycle after handshake.
  logic [31:0] mem [logic [31:0]];
  logic        bp_en = 1'b0;
  int          bp_wr = 0;
  int          bp_st = 0;
  assign mem_req_ready = !(bp_en && bp_wr == 4 && bp_st < 3);

  always @(posedge clk) begin
    mem_rsp_valid <= 1'b0;
    mem_rsp_data  <= 32'h0;
    if (mem_req_valid === 1'b1 && mem_req_ready) begin
      if (mem_req_rw) begin
        mem[mem_req_addr] = mem_req_data;
        bp_wr <= bp_wr + 1;
      end else begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0;
      end
    end
    if (bp_en && mem_req_valid === 1'b1 && mem_req_rw && !mem_req_ready)
      bp_st <= bp_st + 1;
    if (!bp_en) begin
      bp_wr <= 0;
      bp_st <= 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT emits traffic.
  logic        hold_v = 1'b0;
  logic [31:0] hold_a;
  logic [31:0] hold_d;
  always @(negedge clk) begin
    if (nRST === 1'b1) begin
      if (rf_rd_en === 1'b1) begin
        if (exp_rd.size() == 0) chk("rd_extra", 64'(rf_rd_en), 64'(1'b0));
        else chk("rd_addr", 64'(rf_rd_addr), 64'(exp_rd.pop_front()));
      end
      if (mem_req_valid === 1'b1 && mem_req_ready) begin
        hold_v = 1'b0;
        if (mem_req_rw) n_wr_hs++;
        if (exp_mem.size() == 0) begin
          chk("mem_extra", 64'(mem_req_valid), 64'(1'b0));
        end else begin
          mreq_t e;
          e = exp_mem.pop_front();
          chk("mem_addr", 64'(mem_req_addr), 64'(e.addr));
          chk("mem_rw", 64'(mem_req_rw), 64'(e.rw));
          if (e.rw) chk("mem_data", 64'(mem_req_data), 64'(e.data));
        end
      end else if (mem_req_valid === 1'b1) begin
        n_stall++;
        if (hold_v) begin
          chk("stall_addr", 64'(mem_req_addr), 64'(hold_a));
          chk("stall_data", 64'(mem_req_data), 64'(hold_d));
        end
        hold_v = 1'b1;
        hold_a = mem_req_addr;
        hold_d = mem_req_data;
      end else begin
        hold_v = 1'b0;
      end
      if (rf_wr_en === 1'b1) begin
        if (exp_wr.size() == 0) begin
          chk("rfwr_extra", 64'(rf_wr_en), 64'(1'b0));
        end else begin
          wreq_t e;
          e = exp_wr.pop_front();
          chk("rfwr_addr", 64'(rf_wr_addr), 64'(e.addr));
          chk("rfwr_data", 64'(rf_wr_data), 64'(e.data));
        end
      end
      if (done_valid === 1'b1) begin
        if (exp_done.size() == 0)
          chk("done_extra", 64'(done_valid), 64'(1'b0));
        else
          chk("done_info", 64'({done_warp_id, done_err}),
              64'(exp_done.pop_front()));
      end
    end
  end

  function automatic logic [31:0] maddr(int w, int slot, int i);
    return SB + 32'(4 * ((w * 4 + slot) * 20 + i));
  endfunction

  task automatic push_spill(input int w, input int b, input int slot);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a;
      a = {2'(w), 6'((b + i) % 64)};
      exp_rd.push_back(a);
      spilled[w][slot][i] = rf[a];
      exp_mem.push_back('{maddr(w, slot, i), rf[a], 1'b1});
    end
  endtask

  task automatic push_fill(input int w, input int b, input int slot);
    for (int i = 0; i < 20; i++) begin
      exp_mem.push_back('{maddr(w, slot, i), 32'h0, 1'b0});
      exp_wr.push_back('{{2'(w), 6'((b + i) % 64)}, spilled[w][slot][i]});
    end
  endtask

  task automatic do_req(input string tag, input logic fill,
                        input logic [1:0] w, input logic [5:0] b,
                        input int lat);
    int   n;
    logic seen;
    @(posedge clk); #1;
    chk({tag, "_ready"}, 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1; req_fill = fill; req_warp_id = w; req_base = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_fill = 1'b0; req_warp_id = '0; req_base = '0;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (done_valid === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'(1'b1));
    if (seen) chk({tag, "_latency"}, 64'(n), 64'(lat));
    @(posedge clk); #1;
    chk({tag, "_mem_left"}, 64'(exp_mem.size()), 64'(0));
    chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'(0));
    chk({tag, "_rd_left"}, 64'(exp_rd.size()), 64'(0));
    chk({tag, "_done_left"}, 64'(exp_done.size()), 64'(0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1'b1));
    chk({tag, "_busy"}, 64'(busy), 64'(1'b0));
    chk({tag, "_rd_en"}, 64'(rf_rd_en), 64'(1'b0));
    chk({tag, "_wr_en"}, 64'(rf_wr_en), 64'(1'b0));
    chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'(1'b0));
    chk({tag, "_mem_addr"}, 64'(mem_req_addr), 64'(0));
    chk({tag, "_done"}, 64'({done_valid, done_err, done_warp_id}), 64'(0));
  endtask

  initial begin
    int base_hs;
    int k;
    nRST = 1'b0;
    req_valid = 1'b0; req_fill = 1'b0; req_warp_id = '0; req_base = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    nRST = 1'b1;

    exp_done.push_back({2'd0, 1'b1});
    do_req("fill_empty", 1'b1, 2'd0, 6'd0, 2);

    push_spill(1, 4, 0);
    exp_done.push_back({2'd1, 1'b0});
    do_req("spill_w1", 1'b0, 2'd1, 6'd4, 42);

    push_fill(1, 4, 0);
    exp_done.push_back({2'd1, 1'b0});
    do_req("fill_w1", 1'b1, 2'd1, 6'd4, 42);

    exp_done.push_back({2'd1, 1'b1});
    do_req("fill_w1_empty", 1'b1, 2'd1, 6'd4, 2);

    bp_en = 1'b1;
    n_stall = 0;
    push_spill(0, 10, 0);
    exp_done.push_back({2'd0, 1'b0});
    do_req("spill_bp", 1'b0, 2'd0, 6'd10, 45);
    chk("bp_stalls", 64'(n_stall), 64'(3));
    bp_en = 1'b0;

    push_spill(2, 60, 0);
    exp_done.push_back({2'd2, 1'b0});
    do_req("spill_wrap", 1'b0, 2'd2, 6'd60, 42);

    for (int d = 0; d < 4; d++) begin
      push_spill(3, 0, d);
      exp_done.push_back({2'd3, 1'b0});
      do_req("spill_w3", 1'b0, 2'd3, 6'd0, 42);
    end
    exp_done.push_back({2'd3, 1'b1});
    do_req("spill_w3_full", 1'b0, 2'd3, 6'd0, 2);

    push_fill(3, 0, 3);
    exp_done.push_back({2'd3, 1'b0});
    do_req("fill_w3_lifo", 1'b1, 2'd3, 6'd0, 42);

    push_spill(1, 30, 0);
    @(posedge clk); #1;
    base_hs = n_wr_hs;
    req_valid = 1'b1; req_fill = 1'b0; req_warp_id = 2'd1; req_base = 6'd30;
    @(posedge clk); #1;
    req_valid = 1'b0; req_warp_id = '0; req_base = '0;
    k = 0;
    while (n_wr_hs < base_hs + 7 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midspill_reached", 64'(n_wr_hs - base_hs), 64'(7));
    nRST = 1'b0;
    @(posedge clk); #1;
    nRST = 1'b1;
    exp_mem.delete();
    exp_rd.delete();
    exp_done.delete();
    chk_idle("midreset");
    repeat (4) begin
      @(negedge clk);
      chk("midreset_no_done", 64'(done_valid), 64'(1'b0));
    end

    exp_done.push_back({2'd3, 1'b1});
    do_req("post_fill_w3", 1'b1, 2'd3, 6'd0, 2);
    exp_done.push_back({2'd0, 1'b1});
    do_req("post_fill_w0", 1'b1, 2'd0, 6'd0, 2);
    exp_done.push_back({2'd2, 1'b1});
    do_req("post_fill_w2", 1'b1, 2'd2, 6'd0, 2);

    push_spill(3, 5, 0);
    exp_done.push_back({2'd3, 1'b0});
    do_req("post_spill_w3", 1'b0, 2'd3, 6'd5, 42);
    push_fill(3, 5, 0);
    exp_done.push_back({2'd3, 1'b0});
    do_req("post_fill_w3b", 1'b1, 2'd3, 6'd5, 42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vx_wnd_spill_unit.md
Name: VX_wnd_spill_unit

Overview:
Register-window spill/fill engine; the responder to the window decode unit's deschedule request. On window overflow it copies O window registers of a warp from the vector register file to a per-warp spill stack in memory (spill). On underflow-restore it copies them back (fill). It then signals completion so the warp scheduler can reschedule the warp. It serves one request at a time and keeps a per-warp spill depth counter.

Parameters:
N, 8, log2 of vector register file entries (register address = {warp_id, local index})
W, 2, log2 of warp count
O, 20, registers per window (in + local) moved per request
MAX_DEPTH, 4, spilled windows per warp
DATA_W, 32, register/memory word width
ADDR_W, 32, memory address width
SPILL_BASE, 32'h0000_F000, byte base address of the spill area

Ports:
clk  in  1  clock
nRST  in  1  synchronous active-low reset
req_valid  in  1  spill/fill request from window decode unit
req_ready  out  1  engine idle, request accepted when valid&ready
req_fill  in  1  1=fill (restore), 0=spill
req_warp_id  in  W  requesting warp
req_base  in  N-W  first local register index of the window
rf_rd_en  out  1  register file read strobe
rf_rd_addr  out  N  {warp_id, local index}
rf_rd_data  in  DATA_W  read data, valid the cycle after rf_rd_en
rf_wr_en  out  1  register file write strobe
rf_wr_addr  out  N  write address
rf_wr_data  out  DATA_W  write data
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1=write, 0=read
mem_req_addr  out  ADDR_W  byte address
mem_req_data  out  DATA_W  write data
mem_rsp_valid  in  1  read response
mem_rsp_data  in  DATA_W  read data
done_valid  out  1  one-cycle completion pulse
done_warp_id  out  W  warp of the completed request
done_err  out  1  request rejected (overflow/underflow)
busy  out  1  state != IDLE

Behaviour:
- Reset (nRST=0 at a clk edge): state=IDLE; all depth[w]=0; index i=0; every output 0 except req_ready=1. Reset mid-operation abandons the transfer with no done pulse.
- States: IDLE, SP_RD, SP_WR, FL_REQ, FL_WAIT, DONE.
- IDLE: req_ready=1. On accept, latch warp, base and fill; set i=0.
  - Spill with depth[warp]==MAX_DEPTH, or fill with depth[warp]==0 -> DONE with err=1. No rf/mem traffic; depth unchanged.
  - Otherwise spill -> SP_RD; fill -> FL_REQ.
- Register address: rf addr = {warp, (base+i) mod 2^(N-W)}. The local index wraps and never carries into the warp field.
- Memory address: SPILL_BASE + 4*((warp*MAX_DEPTH + slot)*O + i), truncated to ADDR_W.
  - Spill: slot = depth[warp].
  - Fill: slot = depth[warp]-1, so fills are LIFO.
- SP_RD: rf_rd_en=1 for exactly one cycle -> SP_WR.
- SP_WR:
  - On the entry cycle, capture rf_rd_data into a hold register.
  - mem_req_valid=1, rw=1, data=hold; addr and data stay stable until handshake.
  - On mem_req_valid&mem_req_ready: if i==O-1 -> DONE; else i++ and -> SP_RD.
  - Minimum 2 cycles per register.
- FL_REQ: mem_req_valid=1, rw=0. On handshake -> FL_WAIT.
- FL_WAIT: on mem_rsp_valid, in the same cycle drive rf_wr_en=1, rf_wr_addr=current register, rf_wr_data=mem_rsp_data. Then: if i==O-1 -> DONE; else i++ and -> FL_REQ.
- mem_rsp_valid outside FL_WAIT is ignored. Only one memory read is outstanding at a time.
- DONE (1 cycle):
  - done_valid=1, done_warp_id=latched warp, done_err as determined.
  - Non-error spill: depth[warp]++. Non-error fill: depth[warp]--.
  - -> IDLE.
  - A new request can be accepted the cycle after DONE.
- Counters: depth counters are ceil(log2(MAX_DEPTH+1)) bits; i is ceil(log2 O) bits.
- Latency, spill with zero-wait memory: 1 accept + 2*O + 1 done cycles. Fill with 1-cycle response: 1 + 2*O + 1.
- Outputs are glitch-free registered-state decodes. The single exception is rf_wr_* in FL_WAIT, which is combinational from mem_rsp_valid.

Test Plan:
- Spill warp 1, base 4, O=20, mem_req_ready tied 1 -> 20 writes to 0xF000+4*(4*20+i) = 0xF140..0xF18C, data = rf[{1,4+i}]; done_valid pulse with warp 1, err=0; depth[1]=1; total 42 cycles.
- Fill warp 1 after that spill, rsp 1 cycle after each read -> 20 reads from 0xF140..0xF18C; rf writes to addresses {1,4..23} with the returned data; done err=0; depth[1]=0.
- Backpressure: mem_req_ready low 3 cycles on the 5th write -> mem_req_addr/data held constant, i unchanged, no extra rf_rd_en; completes correctly.
- Wrap: spill warp 2, base 60 (N-W=6) -> rf_rd_addr sequence {2,60},{2,61},{2,62},{2,63},{2,0}..{2,15}; never warp 3.
- Errors: fill warp 0 with depth 0 -> done err=1 one cycle after accept, no mem/rf strobes. 5 spills of warp 3 -> 5th done err=1, depth stays 4.
- Reset mid-spill at i=7 -> next cycle IDLE, req_ready=1, all strobes 0, depth[] all 0, no done pulse.
